// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and the line idle level used by both directions.
package uart_pkg;

  localparam int UART_D_W    = 8;
  localparam int UART_B_TICK = 16;

  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_RECOVER = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset
// to RST_VAL so the output never shows a spurious transition out of reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop detection, byte hand-off to the
// RX FIFO, framing and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int D_W    = UART_D_W,
  parameter int B_TICK = UART_B_TICK
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_tick,
  input  logic           rx,
  output logic           baud_en,
  output logic [D_W-1:0] rx_data,
  output logic           rx_done,
  output logic           frame_err,
  output logic           overrun_err,
  output logic           ff_wr_en,
  output logic [D_W-1:0] ff_din,
  input  logic           ff_full
);

  localparam int TW = $clog2(B_TICK);
  localparam int BW = $clog2(D_W + 1);

  localparam logic [TW-1:0] T_MID  = TW'(B_TICK / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(B_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(D_W - 1);

  rx_state_t      state;
  logic           rx_s;
  logic           rx_prev;
  logic           fall;
  logic [TW-1:0]  t_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [D_W-1:0] shreg;

  uart_sync #(.RST_VAL(UART_IDLE_LVL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_prev <= UART_IDLE_LVL;
    else     rx_prev <= rx_s;
  end

  assign fall   = ~rx_s & rx_prev;
  assign ff_din = rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RX_IDLE;
      baud_en     <= 1'b0;
      t_cnt       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_done     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      ff_wr_en    <= 1'b0;
    end else begin
      rx_done     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      ff_wr_en    <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state   <= RX_START;
            t_cnt   <= '0;
            baud_en <= 1'b1;
          end
        end
        RX_START: begin
          if (baud_tick) begin
            if (t_cnt == T_MID) begin
              // A line back high at mid start bit was a glitch, not a frame.
              if (!rx_s) begin
                state   <= RX_DATA;
                t_cnt   <= '0;
                bit_cnt <= '0;
              end else begin
                state   <= RX_IDLE;
                baud_en <= 1'b0;
              end
            end else begin
              t_cnt <= t_cnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (baud_tick) begin
            if (t_cnt == T_END) begin
              shreg   <= {rx_s, shreg[D_W-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              t_cnt   <= '0;
              if (bit_cnt == B_LAST) state <= RX_STOP;
            end else begin
              t_cnt <= t_cnt + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (baud_tick) begin
            if (t_cnt == T_END) begin
              t_cnt   <= '0;
              baud_en <= 1'b0;
              if (rx_s) begin
                rx_data <= shreg;
                rx_done <= 1'b1;
                if (ff_full) overrun_err <= 1'b1;
                else         ff_wr_en    <= 1'b1;
                state <= RX_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= RX_RECOVER;
              end
            end else begin
              t_cnt <= t_cnt + 1'b1;
            end
          end
        end
        RX_RECOVER: begin
          // Hold off until the line returns to idle so a break is one error.
          if (rx_s) state <= RX_IDLE;
        end
        default: begin
          state   <= RX_IDLE;
          baud_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus hand-written sequences
// for back-to-back, glitch and mid-frame reset.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic       baud_en;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       overrun_err;
  logic       ff_wr_en;
  logic [7:0] ff_din;
  logic       ff_full;

  int checks = 0;
  int failures = 0;

  uart_rx #(.D_W(8), .B_TICK(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .baud_en     (baud_en),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .ff_wr_en    (ff_wr_en),
    .ff_din      (ff_din),
    .ff_full     (ff_full)
  );

  always #5 clk = ~clk;

  // free-running tick, one clk in four
  int tc;
  initial begin
    tc = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tc = (tc + 1) % 4;
      baud_tick = (tc == 0);
    end
  end

  int n_done = 0, n_wr = 0, n_fe = 0, n_ov = 0;
  logic [7:0] wq[$];
  logic b2b_mon = 1'b0;
  int run = 0, gaps = 0, max_gap = 0;

  always @(negedge clk) begin
    if (rx_done)     n_done++;
    if (ff_wr_en)    begin n_wr++; wq.push_back(ff_din); end
    if (frame_err)   n_fe++;
    if (overrun_err) n_ov++;
    if (b2b_mon) begin
      if (baud_en) begin
        if (run > 0) begin
          gaps++;
          if (run > max_gap) max_gap = run;
        end
        run = 0;
      end else begin
        run++;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int cyc);
    rx = lvl;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_body(input logic [7:0] d, input logic stop);
    for (int k = 0; k < 8; k++) hold(d[k], 64);
    hold(stop, 64);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold(1'b0, 64);
    send_body(d, stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       full;
    int         e_done;
    int         e_wr;
    int         e_fe;
    int         e_ov;
    logic [7:0] e_rxd;
  } vec_t;

  vec_t vt[4];
  int d0, w0, f0, o0;

  initial begin
    vt[0] = '{8'hA5, 1'b1, 1'b0, 1, 1, 0, 0, 8'hA5};
    vt[1] = '{8'h7E, 1'b1, 1'b1, 1, 0, 0, 1, 8'h7E};
    vt[2] = '{8'h55, 1'b0, 1'b0, 0, 0, 1, 0, 8'h7E};
    vt[3] = '{8'h81, 1'b1, 1'b0, 1, 1, 0, 0, 8'h81};

    rst = 1'b1;
    rx = 1'b1;
    ff_full = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_baud_en", baud_en, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun_err", overrun_err, 0);
    check("rst_ff_wr_en", ff_wr_en, 0);
    check("rst_ff_din", ff_din, 0);
    rst = 1'b0;
    hold(1'b1, 20);

    for (int i = 0; i < 4; i++) begin
      d0 = n_done; w0 = wq.size(); f0 = n_fe; o0 = n_ov;
      ff_full = vt[i].full;
      send_frame(vt[i].data, vt[i].stop);
      if (!vt[i].stop) begin
        hold(1'b0, 200);
        check("recover_baud_en", baud_en, 0);
        check("recover_no_done", n_done - d0, 0);
      end
      hold(1'b1, 20);
      ff_full = 1'b0;
      check($sformatf("v%0d_done", i), n_done - d0, vt[i].e_done);
      check($sformatf("v%0d_wr", i), wq.size() - w0, vt[i].e_wr);
      check($sformatf("v%0d_frame_err", i), n_fe - f0, vt[i].e_fe);
      check($sformatf("v%0d_overrun", i), n_ov - o0, vt[i].e_ov);
      check($sformatf("v%0d_rx_data", i), rx_data, vt[i].e_rxd);
      if (vt[i].e_wr > 0 && wq.size() > w0)
        check($sformatf("v%0d_ff_din", i), wq[w0], vt[i].data);
    end

    // back-to-back frames with no idle gap
    w0 = wq.size();
    hold(1'b0, 10);
    b2b_mon = 1'b1;
    hold(1'b0, 54);
    send_body(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    b2b_mon = 1'b0;
    hold(1'b1, 20);
    check("b2b_writes", wq.size() - w0, 3);
    if (wq.size() >= w0 + 3) begin
      check("b2b_byte0", wq[w0], 8'h00);
      check("b2b_byte1", wq[w0+1], 8'hFF);
      check("b2b_byte2", wq[w0+2], 8'h3C);
    end
    check("b2b_gaps", gaps, 2);
    check("b2b_gap_short", (max_gap >= 20 && max_gap <= 40), 1);

    // glitch shorter than half a bit
    d0 = n_done; w0 = wq.size(); f0 = n_fe; o0 = n_ov;
    hold(1'b0, 10);
    check("glitch_baud_en_on", baud_en, 1);
    hold(1'b0, 10);
    hold(1'b1, 100);
    check("glitch_baud_en_off", baud_en, 0);
    check("glitch_no_pulses", (n_done - d0) + (wq.size() - w0) + (n_fe - f0) + (n_ov - o0), 0);
    check("glitch_rx_data", rx_data, 8'h3C);

    // reset during bit 4 of 0xC3
    hold(1'b0, 64);
    hold(1'b1, 64); hold(1'b1, 64); hold(1'b0, 64); hold(1'b0, 64);
    hold(1'b0, 30);
    rst = 1'b1;
    #1;
    check("midrst_baud_en", baud_en, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_done", rx_done, 0);
    check("midrst_ff_wr_en", ff_wr_en, 0);
    @(negedge clk);
    hold(1'b1, 5);
    rst = 1'b0;
    d0 = n_done; w0 = wq.size();
    hold(1'b1, 20);
    send_frame(8'h12, 1'b1);
    hold(1'b1, 20);
    check("post_rst_done", n_done - d0, 1);
    check("post_rst_rx_data", rx_data, 8'h12);
    if (wq.size() > w0) check("post_rst_ff_din", wq[w0], 8'h12);
    else check("post_rst_wr", wq.size() - w0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
